// File: rtl/tmds_decoder.sv
// rtl/tmds_decoder.sv - two-stage TMDS symbol decoder with HUNT/LOCKED lock tracking
// Optional running-disparity tracker compiled in with TMDS_DISPARITY_CHECK_EN.
module tmds_decoder (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [9:0] tmds_in,
    input  logic       valid_in,
    output logic [7:0] data_out,
    output logic [1:0] control_out,
    output logic       ve_out,
    output logic       valid_out,
    output logic       err_out,
    output logic       disp_err_out,
    output logic       locked_out
);

    localparam logic [9:0] TOK_00 = 10'b1101010100;
    localparam logic [9:0] TOK_01 = 10'b0010101011;
    localparam logic [9:0] TOK_10 = 10'b0101010100;
    localparam logic [9:0] TOK_11 = 10'b1010101011;

    localparam logic [0:0] ST_HUNT   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    // Stage 1: classify and recover the byte
    logic       s1_valid_q, s1_valid_d;
    logic       s1_ctrl_q, s1_ctrl_d;
    logic [1:0] s1_cval_q, s1_cval_d;
    logic [7:0] s1_data_q, s1_data_d;
    logic       s1_method_q, s1_method_d;

    // Stage 2: checked outputs and lock state
    logic [7:0] data_q, data_d;
    logic [1:0] ctrl_q, ctrl_d;
    logic       ve_q, ve_d;
    logic       valid_q, valid_d;
    logic       err_q, err_d;
    logic [0:0] state_q, state_d;
    logic [2:0] run_q, run_d;
    logic [1:0] errc_q, errc_d;

    logic [7:0] sym_q;
    logic [7:0] sym_dec;
    logic       sym_is_ctrl;
    logic [1:0] sym_cval;

    always_comb begin
        sym_q      = tmds_in[9] ? ~tmds_in[7:0] : tmds_in[7:0];
        sym_dec    = 8'h00;
        sym_dec[0] = sym_q[0];
        for (int i = 1; i < 8; i++) begin
            sym_dec[i] = tmds_in[8] ? (sym_q[i] ^ sym_q[i-1]) : ~(sym_q[i] ^ sym_q[i-1]);
        end
    end

    always_comb begin
        sym_is_ctrl = 1'b1;
        sym_cval    = 2'b00;
        case (tmds_in)
            TOK_00:  sym_cval = 2'b00;
            TOK_01:  sym_cval = 2'b01;
            TOK_10:  sym_cval = 2'b10;
            TOK_11:  sym_cval = 2'b11;
            default: sym_is_ctrl = 1'b0;
        endcase
    end

    always_comb begin
        s1_valid_d  = valid_in;
        s1_ctrl_d   = s1_ctrl_q;
        s1_cval_d   = s1_cval_q;
        s1_data_d   = s1_data_q;
        s1_method_d = s1_method_q;
        if (valid_in) begin
            s1_ctrl_d   = sym_is_ctrl;
            s1_cval_d   = sym_is_ctrl ? sym_cval : 2'b00;
            s1_data_d   = sym_is_ctrl ? 8'h00 : sym_dec;
            s1_method_d = tmds_in[8];
        end
    end

    // The encoder chooses XNOR (bit 8 = 0) for byte-heavy data; a mismatch flags a bad symbol.
    logic [3:0] chk_ones;
    logic       chk_pick_xnor;
    logic       chk_err;

    always_comb begin
        chk_ones      = popcount8(s1_data_q);
        chk_pick_xnor = (chk_ones > 4'd4) || ((chk_ones == 4'd4) && !s1_data_q[0]);
        chk_err       = !s1_ctrl_q && (s1_method_q == chk_pick_xnor);
    end

    always_comb begin
        valid_d = s1_valid_q;
        data_d  = data_q;
        ctrl_d  = ctrl_q;
        ve_d    = ve_q;
        err_d   = err_q;
        state_d = state_q;
        run_d   = run_q;
        errc_d  = errc_q;
        if (s1_valid_q) begin
            data_d = s1_data_q;
            ctrl_d = s1_cval_q;
            ve_d   = !s1_ctrl_q;
            err_d  = chk_err;
            if (state_q == ST_HUNT) begin
                if (!s1_ctrl_q) begin
                    run_d = 3'd0;
                end else if (run_q == 3'd7) begin
                    state_d = ST_LOCKED;
                    run_d   = 3'd0;
                end else begin
                    run_d = run_q + 3'd1;
                end
            end else begin
                if (!chk_err) begin
                    errc_d = 2'd0;
                end else if (errc_q == 2'd3) begin
                    state_d = ST_HUNT;
                    errc_d  = 2'd0;
                    run_d   = 3'd0;
                end else begin
                    errc_d = errc_q + 2'd1;
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            s1_valid_q  <= 1'b0;
            s1_ctrl_q   <= 1'b0;
            s1_cval_q   <= 2'b00;
            s1_data_q   <= 8'h00;
            s1_method_q <= 1'b0;
            data_q      <= 8'h00;
            ctrl_q      <= 2'b00;
            ve_q        <= 1'b0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            state_q     <= ST_HUNT;
            run_q       <= 3'd0;
            errc_q      <= 2'd0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_ctrl_q   <= s1_ctrl_d;
            s1_cval_q   <= s1_cval_d;
            s1_data_q   <= s1_data_d;
            s1_method_q <= s1_method_d;
            data_q      <= data_d;
            ctrl_q      <= ctrl_d;
            ve_q        <= ve_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
            state_q     <= state_d;
            run_q       <= run_d;
            errc_q      <= errc_d;
        end
    end

`ifdef TMDS_DISPARITY_CHECK_EN
    function automatic logic [3:0] popcount10(input logic [9:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 10; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    logic        [3:0] s1_ones_q, s1_ones_d;
    logic signed [5:0] tally_q, tally_d;
    logic              derr_q, derr_d;
    logic signed [6:0] tally_sum;

    always_comb begin
        s1_ones_d = valid_in ? popcount10(tmds_in) : s1_ones_q;
    end

    // Tally is the running sum of (ones - 5), clamped to the 6-bit signed range.
    always_comb begin
        tally_sum = {tally_q[5], tally_q} + {3'b000, s1_ones_q} - 7'sd5;
        tally_d   = tally_q;
        derr_d    = derr_q;
        if (s1_valid_q) begin
            if (s1_ctrl_q) begin
                tally_d = 6'sd0;
                derr_d  = 1'b0;
            end else begin
                if (tally_sum > 7'sd31) begin
                    tally_d = 6'sd31;
                end else if (tally_sum < -7'sd31) begin
                    tally_d = -6'sd31;
                end else begin
                    tally_d = tally_sum[5:0];
                end
                if ((tally_sum > 7'sd12) || (tally_sum < -7'sd12)) begin
                    derr_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            s1_ones_q <= 4'd0;
            tally_q   <= 6'sd0;
            derr_q    <= 1'b0;
        end else begin
            s1_ones_q <= s1_ones_d;
            tally_q   <= tally_d;
            derr_q    <= derr_d;
        end
    end

    assign disp_err_out = derr_q;
`else
    assign disp_err_out = 1'b0;
`endif

    assign data_out    = data_q;
    assign control_out = ctrl_q;
    assign ve_out      = ve_q;
    assign valid_out   = valid_q;
    assign err_out     = err_q;
    assign locked_out  = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_tmds_decoder.sv
// tb/tb_tmds_decoder.sv - randomized and directed bench for tmds_decoder against a behavioural model
module tb_tmds_decoder;

    logic       clk_in = 1'b0;
    logic       rst_in = 1'b1;
    logic [9:0] tmds_in = 10'h000;
    logic       valid_in = 1'b0;
    logic [7:0] data_out;
    logic [1:0] control_out;
    logic       ve_out, valid_out, err_out, disp_err_out, locked_out;

    tmds_decoder dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .tmds_in      (tmds_in),
        .valid_in     (valid_in),
        .data_out     (data_out),
        .control_out  (control_out),
        .ve_out       (ve_out),
        .valid_out    (valid_out),
        .err_out      (err_out),
        .disp_err_out (disp_err_out),
        .locked_out   (locked_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic       vo;
        logic [7:0] d;
        logic [1:0] c;
        logic       ve;
        logic       err;
        logic       derr;
        logic       lk;
    } snap_t;

    int checks = 0;
    int errors = 0;
    logic cmp_en = 1'b0;

    snap_t p1 = '0, p2 = '0, last = '0;
    snap_t log_q[$];
    logic [9:0] toks [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

    int   m_locked = 0, m_run = 0, m_errc = 0, m_tally = 0;
    logic m_derr = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_sym(input logic [9:0] t, output snap_t e);
        logic [7:0] q, d;
        logic       is_c, pick_xnor, bad;
        logic [1:0] cv;
        int         n;
        is_c = 1'b1;
        cv   = 2'd0;
        case (t)
            10'h354: cv = 2'd0;
            10'h0AB: cv = 2'd1;
            10'h154: cv = 2'd2;
            10'h2AB: cv = 2'd3;
            default: is_c = 1'b0;
        endcase
        q = t[9] ? ~t[7:0] : t[7:0];
        d = 8'h00;
        d[0] = q[0];
        for (int i = 1; i < 8; i++) d[i] = t[8] ? (q[i] ^ q[i-1]) : !(q[i] ^ q[i-1]);
        n = $countones(d);
        pick_xnor = (n > 4) || (n == 4 && d[0] == 1'b0);
        bad = !is_c && (t[8] == pick_xnor);
        if (is_c) d = 8'h00;
        if (m_locked == 0) begin
            if (is_c) begin
                m_run++;
                if (m_run == 8) begin m_locked = 1; m_run = 0; end
            end else m_run = 0;
        end else begin
            if (bad) begin
                m_errc++;
                if (m_errc == 4) begin m_locked = 0; m_errc = 0; m_run = 0; end
            end else m_errc = 0;
        end
`ifdef TMDS_DISPARITY_CHECK_EN
        if (is_c) begin
            m_tally = 0;
            m_derr  = 1'b0;
        end else begin
            m_tally = m_tally + $countones(t) - 5;
            if (m_tally > 12 || m_tally < -12) m_derr = 1'b1;
            if (m_tally > 31) m_tally = 31;
            if (m_tally < -31) m_tally = -31;
        end
`endif
        e.vo = 1'b1; e.d = d; e.c = is_c ? cv : 2'd0; e.ve = !is_c;
        e.err = bad; e.derr = m_derr; e.lk = (m_locked != 0);
    endtask

    always @(posedge clk_in) begin
        snap_t e;
        if (rst_in) begin
            p1 = '0; p2 = '0; last = '0;
            m_locked = 0; m_run = 0; m_errc = 0; m_tally = 0; m_derr = 1'b0;
        end else begin
            p2 = p1;
            if (valid_in) begin
                model_sym(tmds_in, e);
                last = e;
            end else begin
                e = last;
                e.vo = 1'b0;
            end
            p1 = e;
        end
    end

    always @(negedge clk_in) begin
        if (cmp_en) begin
            chk("outputs_vs_model",
                {valid_out, data_out, control_out, ve_out, err_out, disp_err_out, locked_out}, p2);
            if (valid_out)
                log_q.push_back({valid_out, data_out, control_out, ve_out, err_out, disp_err_out, locked_out});
        end
    end

    function automatic snap_t lg(input int i);
        if (i < log_q.size()) return log_q[i];
        return '0;
    endfunction

    task automatic drive(input logic [9:0] t, input logic v, input logic r);
        @(posedge clk_in);
        #1;
        tmds_in  = t;
        valid_in = v;
        rst_in   = r;
    endtask

    task automatic drain();
        repeat (3) drive(10'h000, 1'b0, 1'b0);
    endtask

    initial begin
        logic [9:0] t;
        logic [7:0] dexp;
        repeat (2) @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        cmp_en = 1'b1;
        @(negedge clk_in);
        chk("reset_state", {valid_out, data_out, control_out, ve_out, err_out, disp_err_out, locked_out}, 0);

        // Eight 00 tokens acquire lock on the eighth output
        log_q.delete();
        repeat (8) drive(10'h354, 1'b1, 1'b0);
        drain();
        chk("lock_count", log_q.size(), 8);
        chk("lock_tok0", {lg(0).c, lg(0).ve}, 0);
        chk("lock_7th_lk", lg(6).lk, 0);
        chk("lock_8th_lk", {lg(7).c, lg(7).ve, lg(7).lk}, 3'b001);

        log_q.delete();
        drive(10'h100, 1'b1, 1'b0);
        drive(10'h200, 1'b1, 1'b0);
        drain();
        chk("data_100", {lg(0).d, lg(0).ve, lg(0).err}, {8'h00, 2'b10});
        chk("data_200", {lg(1).d, lg(1).ve, lg(1).err}, {8'hFF, 2'b10});

        log_q.delete();
        repeat (4) drive(10'h155, 1'b1, 1'b0);
        drain();
        for (int i = 0; i < 4; i++) chk("err155", {lg(i).d, lg(i).err}, {8'hFF, 1'b1});
        chk("err_3rd_lk", lg(2).lk, 1);
        chk("err_4th_unlock", lg(3).lk, 0);

        log_q.delete();
        repeat (8) drive(10'h354, 1'b1, 1'b0);
        repeat (3) drive(10'h155, 1'b1, 1'b0);
        drive(10'h100, 1'b1, 1'b0);
        drive(10'h155, 1'b1, 1'b0);
        drain();
        chk("good_breaks_run_err", lg(11).err, 0);
        chk("still_locked", lg(12).lk, 1);

        log_q.delete();
        drive(10'h0AB, 1'b1, 1'b0);
        drive(10'h000, 1'b0, 1'b0);
        drive(10'h154, 1'b1, 1'b0);
        drive(10'h000, 1'b0, 1'b0);
        drive(10'h2AB, 1'b1, 1'b0);
        drain();
        chk("tok_ctrl", {lg(0).c, lg(1).c, lg(2).c}, 6'b01_10_11);

        drive(10'h000, 1'b0, 1'b1);
        log_q.delete();
        repeat (4) drive(10'h100, 1'b1, 1'b0);
        drive(10'h354, 1'b1, 1'b0);
        drain();
`ifdef TMDS_DISPARITY_CHECK_EN
        chk("disp_seq", {lg(0).derr, lg(1).derr, lg(2).derr, lg(3).derr, lg(4).derr}, 5'b00010);
`else
        chk("disp_seq", {lg(0).derr, lg(1).derr, lg(2).derr, lg(3).derr, lg(4).derr}, 5'b00000);
`endif

        // Reset with two symbols in flight while locked
        repeat (8) drive(10'h354, 1'b1, 1'b0);
        drain();
        log_q.delete();
        drive(10'h100, 1'b1, 1'b0);
        drive(10'h200, 1'b1, 1'b1);
        drain();
        chk("rst_no_valid", log_q.size(), 0);
        chk("rst_outputs", {valid_out, data_out, control_out, ve_out, err_out, disp_err_out, locked_out}, 0);

        for (int s = 0; s < 250; s++) begin
            int kind;
            int len;
            kind = $urandom_range(0, 3);
            len  = $urandom_range(3, 12);
            for (int k = 0; k < len; k++) begin
                case (kind)
                    0: t = toks[$urandom_range(0, 3)];
                    1: t = 10'($urandom);
                    2: begin
                        case ($urandom_range(0, 3))
                            0: t = 10'h155;
                            1: t = 10'h100;
                            2: t = 10'h3FF;
                            default: t = 10'h200;
                        endcase
                    end
                    default: t = ($urandom_range(0, 1) != 0) ? toks[$urandom_range(0, 3)] : 10'($urandom);
                endcase
                drive(t, $urandom_range(0, 3) != 0, $urandom_range(0, 399) == 0);
            end
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
